// File: rtl/seq_alu_pkg.sv
// Shared opcodes, flag indices and controller states for seq_alu.
// SEQ_ALU_MUL_EN appends FnMUL and the MUL state.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        FnA    = 5'd0,
        FnB    = 5'd1,
        FnADD  = 5'd2,
        FnADC  = 5'd3,
        FnSUB  = 5'd4,
        FnSUC  = 5'd5,
        FnNEG  = 5'd6,
        FnAND  = 5'd7,
        FnOR   = 5'd8,
        FnXOR  = 5'd9,
        FnNOT  = 5'd10,
        FnNAND = 5'd11,
        FnNOR  = 5'd12,
        FnLUI  = 5'd13,
        FnLLI  = 5'd14,
        FnLSL  = 5'd15,
        FnLSR  = 5'd16,
        FnASR  = 5'd17
`ifdef SEQ_ALU_MUL_EN
        , FnMUL = 5'd18
`endif
    } alu_functions_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT
`ifdef SEQ_ALU_MUL_EN
        , MUL
`endif
    } alu_state_t;

    function automatic logic is_shift(input logic [4:0] f);
        return (f == FnLSL) || (f == FnLSR) || (f == FnASR);
    endfunction

    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic v, input logic n);
        logic [3:0] fl;
        fl         = '0;
        fl[FLAG_Z] = z;
        fl[FLAG_C] = c;
        fl[FLAG_V] = v;
        fl[FLAG_N] = n;
        return fl;
    endfunction

endpackage

// File: rtl/seq_alu_adder.sv
// WIDTH-bit combinational adder with carry-out and signed-overflow outputs.
module seq_alu_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    // Overflow: both addends share a sign that the sum does not.
    assign o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, bit-serial shifts and, when
// SEQ_ALU_MUL_EN is defined, a bit-serial shift-add multiply.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = SHAMT_W + 1;

    if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("seq_alu: WIDTH must be even and at least 8");
    end

    alu_state_t       r_state;
    logic [4:0]       r_func;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;
    logic [SHAMT_W-1:0] w_amt;

    assign w_amt = B[SHAMT_W-1:0];

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] w_prod_next;
    assign w_prod_next = {w_cout, w_sum, r_prod[WIDTH-1:1]};
`endif

    seq_alu_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // Subtraction and negation reuse the adder through an inverted operand.
    always_comb begin
        w_add_a   = r_a;
        w_add_b   = r_b;
        w_add_cin = 1'b0;
        case (r_func)
            FnADC: w_add_cin = r_cin;
            FnSUB: begin w_add_b = ~r_b; w_add_cin = 1'b1;  end
            FnSUC: begin w_add_b = ~r_b; w_add_cin = r_cin; end
            FnNEG: begin w_add_a = '0; w_add_b = ~r_a; w_add_cin = 1'b1; end
            default: ;
        endcase
`ifdef SEQ_ALU_MUL_EN
        if (r_state == MUL) begin
            w_add_a   = r_prod[2*WIDTH-1:WIDTH];
            w_add_b   = r_prod[0] ? r_mcand : '0;
            w_add_cin = 1'b0;
        end
`endif
    end

    always_comb begin
        w_res   = '0;
        w_flags = pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
        case (r_func)
            FnA, FnB, FnAND, FnOR, FnXOR, FnNOT, FnNAND, FnNOR, FnLUI, FnLLI,
            FnLSL, FnLSR, FnASR: begin
                case (r_func)
                    FnA:     w_res = r_a;
                    FnB:     w_res = r_b;
                    FnAND:   w_res = r_a & r_b;
                    FnOR:    w_res = r_a | r_b;
                    FnXOR:   w_res = r_a ^ r_b;
                    FnNOT:   w_res = ~r_a;
                    FnNAND:  w_res = ~(r_a & r_b);
                    FnNOR:   w_res = ~(r_a | r_b);
                    FnLUI:   w_res = {r_b[HALF-1:0], r_a[HALF-1:0]};
                    FnLLI:   w_res = {r_a[WIDTH-1:HALF], r_b[HALF-1:0]};
                    default: w_res = r_a;
                endcase
                w_flags = pack_flags(w_res == '0, 1'b0, 1'b0, w_res[WIDTH-1]);
            end
            FnADD, FnADC, FnSUB, FnSUC, FnNEG: begin
                w_res   = w_sum;
                w_flags = pack_flags(w_sum == '0, w_cout, w_ovf, w_sum[WIDTH-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sh_next = r_sh;
        w_sh_out  = 1'b0;
        case (r_func)
            FnLSL: begin w_sh_out = r_sh[WIDTH-1]; w_sh_next = {r_sh[WIDTH-2:0], 1'b0}; end
            FnLSR: begin w_sh_out = r_sh[0]; w_sh_next = {1'b0, r_sh[WIDTH-1:1]}; end
            FnASR: begin w_sh_out = r_sh[0]; w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]}; end
            default: ;
        endcase
    end

    // Operand and working registers carry no reset; control gates their use.
    always_ff @(posedge Clock) begin
        if (Ready && Start) begin
            r_func  <= Func;
            r_a     <= A;
            r_b     <= B;
            r_cin   <= CarryIn;
            r_sh    <= A;
`ifdef SEQ_ALU_MUL_EN
            r_prod  <= {{WIDTH{1'b0}}, B};
            r_mcand <= A;
`endif
        end else if (r_state == SHIFT) begin
            r_sh <= w_sh_next;
        end
`ifdef SEQ_ALU_MUL_EN
        else if (r_state == MUL) begin
            r_prod <= w_prod_next;
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            Ready   <= 1'b1;
            Done    <= 1'b0;
            Result  <= '0;
            Flags   <= '0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        Ready <= 1'b0;
                        if (is_shift(Func) && w_amt != '0) begin
                            r_state <= SHIFT;
                            r_cnt   <= {1'b0, w_amt};
                        end
`ifdef SEQ_ALU_MUL_EN
                        else if (Func == FnMUL) begin
                            r_state <= MUL;
                            r_cnt   <= CNT_W'(WIDTH);
                        end
`endif
                        else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    Result  <= w_res;
                    Flags   <= w_flags;
                    Done    <= 1'b1;
                    Ready   <= 1'b1;
                    r_state <= IDLE;
                end
                SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        Result  <= w_sh_next;
                        Flags   <= pack_flags(w_sh_next == '0, w_sh_out, 1'b0,
                                              w_sh_next[WIDTH-1]);
                        Done    <= 1'b1;
                        Ready   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        Result  <= w_prod_next[WIDTH-1:0];
                        Flags   <= pack_flags(w_prod_next[WIDTH-1:0] == '0,
                                              |w_prod_next[2*WIDTH-1:WIDTH], 1'b0,
                                              w_prod_next[WIDTH-1]);
                        Done    <= 1'b1;
                        Ready   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    Ready   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16.
// Honours SEQ_ALU_MUL_EN for the code-18 expectations.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [4:0]  Func;
    logic [15:0] A;
    logic [15:0] B;
    logic        CarryIn;
    logic        Ready;
    logic        Done;
    logic [15:0] Result;
    logic [3:0]  Flags;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(16)) dut (
        .Clock   (clk),
        .Reset   (Reset),
        .Start   (Start),
        .Func    (Func),
        .A       (A),
        .B       (B),
        .CarryIn (CarryIn),
        .Ready   (Ready),
        .Done    (Done),
        .Result  (Result),
        .Flags   (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] r;
        logic [3:0]  fl;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        Func = f; A = a; B = b; CarryIn = c; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Func = '0; A = '0; B = '0; CarryIn = 1'b0;
        tick();
        checks++;
        if (Ready !== 1'b1 || Done !== 1'b0 || Result !== 16'h0 || Flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b done=%b res=%h fl=%b exp 1 0 0000 0000",
                     Ready, Done, Result, Flags);
        end
        @(negedge clk);
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_ops();
        vec_t tbl[14];
        tbl = '{
            '{FnADC,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0011},
            '{FnSUC,  16'h0005, 16'h0005, 1'b0, 16'hFFFF, 4'b1000},
            '{FnNEG,  16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b1100},
            '{FnNEG,  16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0011},
            '{FnSUB,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b1000},
            '{FnNAND, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0001},
            '{FnLUI,  16'h1234, 16'hABCD, 1'b0, 16'hCD34, 4'b1000},
            '{FnLLI,  16'h1234, 16'hABCD, 1'b0, 16'h12CD, 4'b0000},
            '{FnXOR,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 4'b0000},
            '{FnNOT,  16'h00FF, 16'h0000, 1'b0, 16'hFF00, 4'b1000},
            '{5'd31,  16'h1111, 16'h2222, 1'b1, 16'h0000, 4'b0001},
            '{FnLSR,  16'h8001, 16'h0000, 1'b0, 16'h8001, 4'b1000},
            '{FnLSR,  16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b0011},
            '{FnOR,   16'h0A00, 16'h00B0, 1'b0, 16'h0AB0, 4'b0000}
        };
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].cin);
            checks++;
            if (Done !== 1'b0 || Ready !== 1'b0) begin
                errors++;
                $display("FAIL ops[%0d]_busy got done=%b rdy=%b exp 0 0", i, Done, Ready);
            end
            tick();
            checks++;
            if (Done !== 1'b1 || Result !== tbl[i].r || Flags !== tbl[i].fl) begin
                errors++;
                $display("FAIL ops[%0d] got done=%b res=%h fl=%b exp 1 %h %b",
                         i, Done, Result, Flags, tbl[i].r, tbl[i].fl);
            end
        end
        tick();
    endtask

    task automatic test_add_overflow();
        issue(FnADD, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        checks++;
        if (Done !== 1'b1 || Ready !== 1'b1 || Result !== 16'h8000 || Flags !== 4'b1100) begin
            errors++;
            $display("FAIL add_ovf got done=%b rdy=%b res=%h fl=%b exp 1 1 8000 1100",
                     Done, Ready, Result, Flags);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Result !== 16'h8000 || Flags !== 4'b1100) begin
            errors++;
            $display("FAIL add_hold got done=%b res=%h fl=%b exp 0 8000 1100",
                     Done, Result, Flags);
        end
    endtask

    task automatic test_back_to_back();
        issue(FnSUB, 16'd5, 16'd5, 1'b0);
        tick();
        checks++;
        if (Done !== 1'b1 || Ready !== 1'b1 || Result !== 16'h0000 || Flags !== 4'b0011) begin
            errors++;
            $display("FAIL sub_eq got done=%b rdy=%b res=%h fl=%b exp 1 1 0000 0011",
                     Done, Ready, Result, Flags);
        end
        issue(FnADD, 16'd3, 16'd4, 1'b0);
        checks++;
        if (Done !== 1'b0 || Ready !== 1'b0 || Result !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_accept got done=%b rdy=%b res=%h exp 0 0 0000",
                     Done, Ready, Result);
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Result !== 16'h0007 || Flags !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_add got done=%b res=%h fl=%b exp 1 0007 0000",
                     Done, Result, Flags);
        end
        tick();
    endtask

    task automatic test_asr();
        issue(FnASR, 16'h8018, 16'd4, 1'b0);
        checks++;
        if (Ready !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL asr_edge0 got rdy=%b done=%b exp 0 0", Ready, Done);
        end
        for (int e = 1; e < 4; e++) begin
            tick();
            checks++;
            if (Ready !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL asr_edge%0d got rdy=%b done=%b exp 0 0", e, Ready, Done);
            end
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Ready !== 1'b1 || Result !== 16'hF801 || Flags !== 4'b1010) begin
            errors++;
            $display("FAIL asr_done got done=%b rdy=%b res=%h fl=%b exp 1 1 F801 1010",
                     Done, Ready, Result, Flags);
        end
        tick();
    endtask

    task automatic test_start_held();
        int dones = 0;
        int done_edge = -1;
        Func = FnLSL; A = 16'h0003; B = 16'd15; CarryIn = 1'b0; Start = 1'b1;
        tick();
        A = 16'h0000; B = 16'd1; Func = FnA;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (Done === 1'b1) begin
                dones++;
                done_edge = e;
            end
        end
        Start = 1'b0;
        checks++;
        if (dones != 1 || done_edge != 15) begin
            errors++;
            $display("FAIL lsl_held_done got count=%0d edge=%0d exp 1 15", dones, done_edge);
        end
        checks++;
        if (Result !== 16'h8000 || Flags !== 4'b1010) begin
            errors++;
            $display("FAIL lsl_held_res got res=%h fl=%b exp 8000 1010", Result, Flags);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Ready !== 1'b1) begin
            errors++;
            $display("FAIL lsl_held_after got done=%b rdy=%b exp 0 1", Done, Ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(FnLSR, 16'hFFFF, 16'd10, 1'b0);
        tick();
        tick();
        @(negedge clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (Result !== 16'h0 || Flags !== 4'h0 || Done !== 1'b0 || Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async got res=%h fl=%b done=%b rdy=%b exp 0000 0000 0 1",
                     Result, Flags, Done, Ready);
        end
        tick();
        Reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (Done !== 1'b0 || Ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_abandon[%0d] got done=%b rdy=%b exp 0 1", e, Done, Ready);
            end
        end
    endtask

    task automatic test_code18();
        int lat = 0;
`ifdef SEQ_ALU_MUL_EN
        int          exp_lat = 16;
        logic [15:0] exp_res = 16'h5F90;
        logic [3:0]  exp_fl  = 4'b0010;
`else
        int          exp_lat = 1;
        logic [15:0] exp_res = 16'h0000;
        logic [3:0]  exp_fl  = 4'b0001;
`endif
        issue(5'd18, 16'd300, 16'd300, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (Done === 1'b1) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL code18_latency got %0d exp %0d", lat, exp_lat);
        end
        checks++;
        if (Result !== exp_res || Flags !== exp_fl) begin
            errors++;
            $display("FAIL code18_result got res=%h fl=%b exp %h %b",
                     Result, Flags, exp_res, exp_fl);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_add_overflow();
        test_back_to_back();
        test_asr();
        test_start_held();
        test_reset_mid_shift();
        test_code18();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL take parameter WIDTH, default 16, as the datapath width; it must be even and at least 8.
REQ-002 SHALL take derived parameter SHAMT_W, default $clog2(WIDTH), as the shift-amount field width.
REQ-003 SHALL have port Clock  in  1  as the single clock; one clock, all state on rising edge.
REQ-004 SHALL have port Reset  in  1  as the reset, which is asynchronous and active-high.
REQ-005 SHALL have port Start  in  1  as the operation request, sampled on the rising edge.
REQ-006 SHALL have port Func  in  5  as the alu_functions_t code.
REQ-007 SHALL have ports A, B  in  WIDTH  as the operands; B[SHAMT_W-1:0] is the shift amount for shifts.
REQ-008 SHALL have port CarryIn  in  1  as the carry input for FnADC/FnSUC.
REQ-009 SHALL have port Ready  out  1  as idle status, meaning a request can be accepted.
REQ-010 SHALL have port Done  out  1  as a one-cycle result-valid pulse.
REQ-011 SHALL have port Result  out  WIDTH  as the registered result.
REQ-012 SHALL have port Flags  out  4  as the registered flags, indexed Z=0, C=1, V=2, N=3.

Function
REQ-013 SHALL use states IDLE, EXEC and SHIFT (plus MUL when configured), with Ready=1 only in IDLE.
REQ-014 SHALL accept a request on the edge where Start=1 and Ready=1, capturing Func, A, B and CarryIn.
REQ-015 SHALL ignore Start while Ready=0, with no queuing.
REQ-016 SHALL, for non-shift codes, go IDLE->EXEC->IDLE, updating Result/Flags and raising Done one edge after acceptance.
REQ-017 SHALL, for FnLSL/FnLSR/FnASR with amount n>=1, shift one bit per edge in SHIFT and update Result/Flags/Done at edge n after acceptance; n=0 behaves as 1-cycle EXEC with Result=A and C=0.
REQ-018 SHALL hold Done high for exactly one cycle and return to IDLE on the same edge, so back-to-back accepts are allowed the cycle Done is high.
REQ-019 SHALL hold Result/Flags until the next Done.
REQ-020 SHALL compute FnA=A, FnB=B, FnADD=A+B, FnADC=A+B+CarryIn, FnSUB=A+~B+1, FnSUC=A+~B+CarryIn, FnNEG=~A+1.
REQ-021 SHALL compute the logic ops AND/OR/XOR/NOT(A)/NAND/NOR bitwise.
REQ-022 SHALL compute, with H=WIDTH/2, FnLUI={B[H-1:0],A[H-1:0]} and FnLLI={A[WIDTH-1:H],B[H-1:0]}.
REQ-023 SHALL set Z = (Result==0) and N = Result[WIDTH-1] for every code.
REQ-024 SHALL set C = carry-out of the WIDTH-bit add for arithmetic codes (SUB: 1 = no borrow), the last bit shifted out for shifts, and 0 for all other codes.
REQ-025 SHALL set V = signed overflow for arithmetic codes, and 0 for all other codes.
REQ-026 SHALL treat any unsupported code as 1-cycle, Result=0, Flags=4'b0001.

Reset
REQ-027 SHALL, on Reset asserted (including mid-operation), immediately force state IDLE, Result=0, Flags=0, Done=0 and Ready=1, abandoning the in-flight operation.
REQ-028 SHALL produce no Done for an abandoned operation.

Configuration
REQ-029 SHALL, with SEQ_ALU_MUL_EN defined, add FnMUL (5'd18) as a shift-add multiply, one bit per edge, Done at edge WIDTH after acceptance, Result = low WIDTH bits of A*B, C = 1 iff the high WIDTH bits are nonzero, V=0.
REQ-030 SHALL, without SEQ_ALU_MUL_EN, exclude MUL state and logic and handle code 18 per REQ-026.

Structure
REQ-031 SHALL keep alu_functions_t (with FnMUL appended under SEQ_ALU_MUL_EN), the flag index constants and the state enum in the shared opcodes package.
REQ-032 SHALL place the combinational WIDTH-bit adder with carry/overflow outputs in one sub-module, seq_alu_adder, instantiated once.

Verification (WIDTH=16)
REQ-033 SHALL cover FnADD A=16'h7FFF B=16'h0001 -> Result 16'h8000, Flags 4'b1100, Done 1 edge after accept.
REQ-034 SHALL cover FnSUB A=5 B=5 -> Result 0, Flags 4'b0011; then FnADD accepted on the Done cycle completes with no lost cycle.
REQ-035 SHALL cover FnASR A=16'h8018 B=4 -> Ready low for 4 cycles, Result 16'hF801, Flags 4'b1010, Done at edge 4.
REQ-036 SHALL cover FnLSL B=15 with Start held high throughout -> extra Starts ignored, exactly one Done at edge 15.
REQ-037 SHALL cover Reset pulsed at edge 3 of a 10-bit shift -> Result/Flags/Done 0 and Ready 1 asynchronously, with no later Done.
REQ-038 SHALL cover code 18 with A=300 B=300: with SEQ_ALU_MUL_EN -> Result 16'h5F90, C=1, Done at edge 16; without -> Result 0, Flags 4'b0001.
